// File: rtl/btb_pkg.sv
// btb_pkg: counter encodings, allocation preset and tag slice bounds shared by the BTB files
package btb_pkg;
    typedef logic [1:0] ctr_t;
    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT = 2'b10;
    localparam ctr_t ST = 2'b11;
    localparam ctr_t PRESET = ST;
    localparam int TAG_HI = 31;
    localparam int TAG_LO = 2;
    localparam int TAG_W = TAG_HI - TAG_LO + 1;
endpackage

// File: rtl/btb_entry.sv
// btb_entry: one fully-associative BTB entry (valid/tag/target/2-bit counter) with match ports
// Ports: clk/rst_n; clear invalidates; if_tag/ex_tag -> if_match/ex_match;
//        alloc loads a fresh entry, upd applies a resolved outcome (taken, ex_target);
//        valid/target/cnt expose the stored state.
module btb_entry
    import btb_pkg::*;
#(
    parameter ctr_t PRESET_STATE = PRESET
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [TAG_W-1:0]  if_tag,
    input  logic [TAG_W-1:0]  ex_tag,
    input  logic              alloc,
    input  logic              upd,
    input  logic              taken,
    input  logic [31:0]       ex_target,
    output logic              if_match,
    output logic              ex_match,
    output logic              valid,
    output logic [31:0]       target,
    output ctr_t              cnt
);
    logic [TAG_W-1:0] tag;
    ctr_t cnt_next;
    assign if_match = valid && (tag == if_tag);
    assign ex_match = valid && (tag == ex_tag);
    assign cnt_next = taken ? ((cnt == ST) ? ST : cnt + 2'd1) : ((cnt == SNT) ? SNT : cnt - 2'd1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag <= '0;
            target <= '0;
            cnt <= SNT;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (alloc) begin
            valid <= 1'b1;
            tag <= ex_tag;
            target <= ex_target;
            cnt <= PRESET_STATE;
        end else if (upd) begin
            cnt <= cnt_next;
            if (taken) target <= ex_target;
        end
    end
endmodule

// File: rtl/btb_alloc_controller.sv
// btb_alloc_controller: fully-associative BTB with lookup, outcome update, victim allocation and redirect
// Ports: CLK/RST_N; IF_PC -> IF_Hit/IF_Target/IF_JumpPredict (same-cycle lookup);
//        EX_* resolved branch info drives update/allocate; Clear invalidates all;
//        Redirect/Redirect_PC request a fetch flush on mispredict.
module btb_alloc_controller
    import btb_pkg::*;
#(
    parameter int   ENTRIES = 8,
    parameter ctr_t PRESET_STATE = PRESET
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IF_PC,
    output logic        IF_Hit,
    output logic [31:0] IF_Target,
    output logic        IF_JumpPredict,
    input  logic        EX_Valid,
    input  logic [31:0] EX_PC,
    input  logic [31:0] EX_Target,
    input  logic        EX_Taken,
    input  logic        EX_PredTaken,
    input  logic [31:0] EX_PredTarget,
    input  logic        Clear,
    output logic        Redirect,
    output logic [31:0] Redirect_PC
);
    localparam int IW = $clog2(ENTRIES);
    logic [ENTRIES-1:0] if_match, ex_match, valid, alloc, upd;
    logic [31:0] target [ENTRIES];
    ctr_t cnt [ENTRIES];
    logic [IW-1:0] rr_ptr, victim;
    logic all_valid, alloc_req;
    genvar g;
    generate
        for (g = 0; g < ENTRIES; g++) begin : g_entry
            btb_entry #(.PRESET_STATE(PRESET_STATE)) u_entry (
                .clk(CLK), .rst_n(RST_N), .clear(Clear),
                .if_tag(IF_PC[TAG_HI:TAG_LO]), .ex_tag(EX_PC[TAG_HI:TAG_LO]),
                .alloc(alloc[g]), .upd(upd[g]), .taken(EX_Taken), .ex_target(EX_Target),
                .if_match(if_match[g]), .ex_match(ex_match[g]),
                .valid(valid[g]), .target(target[g]), .cnt(cnt[g])
            );
        end
    endgenerate
    assign all_valid = &valid;
    assign alloc_req = EX_Valid && !Clear && EX_Taken && !(|ex_match);
    assign upd = (EX_Valid && !Clear) ? ex_match : '0;
    always_comb begin
        IF_Hit = |if_match;
        IF_Target = '0;
        IF_JumpPredict = 1'b0;
        victim = rr_ptr;
        alloc = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            IF_Target = IF_Target | (if_match[i] ? target[i] : 32'd0);
            IF_JumpPredict = IF_JumpPredict | (if_match[i] & cnt[i][1]);
        end
        // Descending scan so the lowest-index invalid entry is the last assignment.
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!valid[i]) victim = IW'(i);
        if (alloc_req) alloc[victim] = 1'b1;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rr_ptr <= '0;
        else if (Clear) rr_ptr <= '0;
        else if (alloc_req && all_valid) rr_ptr <= rr_ptr + 1'b1;
    end
    assign Redirect = EX_Valid && ((EX_Taken != EX_PredTaken) || (EX_Taken && (EX_PredTarget != EX_Target)));
    assign Redirect_PC = Redirect ? (EX_Taken ? EX_Target : EX_PC + 32'd4) : 32'd0;
endmodule

// File: tb/tb_btb_alloc_controller.sv
// tb_btb_alloc_controller: directed self-checking bench for btb_alloc_controller
module tb_btb_alloc_controller;
    logic CLK = 0, RST_N = 0;
    logic [31:0] IF_PC = 0, EX_PC = 0, EX_Target = 0, EX_PredTarget = 0;
    logic EX_Valid = 0, EX_Taken = 0, EX_PredTaken = 0, Clear = 0;
    logic IF_Hit, IF_JumpPredict, Redirect;
    logic [31:0] IF_Target, Redirect_PC;
    int checks = 0, failures = 0;

    btb_alloc_controller dut (
        .CLK(CLK), .RST_N(RST_N), .IF_PC(IF_PC), .IF_Hit(IF_Hit), .IF_Target(IF_Target),
        .IF_JumpPredict(IF_JumpPredict), .EX_Valid(EX_Valid), .EX_PC(EX_PC),
        .EX_Target(EX_Target), .EX_Taken(EX_Taken), .EX_PredTaken(EX_PredTaken),
        .EX_PredTarget(EX_PredTarget), .Clear(Clear), .Redirect(Redirect),
        .Redirect_PC(Redirect_PC)
    );

    always #5 CLK = ~CLK;

    task automatic ex_set(input logic [31:0] pc, tgt, input logic tk, ptk, input logic [31:0] ptgt);
        EX_Valid = 1; EX_PC = pc; EX_Target = tgt; EX_Taken = tk; EX_PredTaken = ptk; EX_PredTarget = ptgt;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
        EX_Valid = 0; Clear = 0;
        #1;
    endtask

    task automatic alloc(input logic [31:0] pc, tgt);
        ex_set(pc, tgt, 1, 1, tgt);
        tick();
    endtask

    task automatic lookup(input logic [31:0] pc);
        IF_PC = pc; #1;
    endtask

    task automatic test_reset();
        RST_N = 0;
        ex_set(32'h10, 32'h80, 1, 0, 32'h0);
        lookup(32'h10);
        checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%0b exp=0", IF_Hit); end
        checks++; if (IF_Target !== 32'h0) begin failures++; $display("FAIL rst_target got=%0h exp=0", IF_Target); end
        checks++; if (IF_JumpPredict !== 1'b0) begin failures++; $display("FAIL rst_pred got=%0b exp=0", IF_JumpPredict); end
        checks++; if (dut.rr_ptr !== 3'd0) begin failures++; $display("FAIL rst_rr got=%0d exp=0", dut.rr_ptr); end
        checks++; if (Redirect !== 1'b1 || Redirect_PC !== 32'h80) begin failures++; $display("FAIL rst_redirect got=%0b/%0h exp=1/80", Redirect, Redirect_PC); end
        tick();
        lookup(32'h10);
        checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL rst_no_alloc got=%0b exp=0", IF_Hit); end
        RST_N = 1;
        #1;
    endtask

    task automatic test_cold_alloc();
        lookup(32'h100);
        ex_set(32'h100, 32'h200, 1, 0, 32'h0);
        checks++; if (Redirect !== 1'b1 || Redirect_PC !== 32'h200) begin failures++; $display("FAIL cold_redirect got=%0b/%0h exp=1/200", Redirect, Redirect_PC); end
        checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL cold_same_cycle got=%0b exp=0", IF_Hit); end
        tick();
        checks++; if (IF_Hit !== 1'b1 || IF_Target !== 32'h200 || IF_JumpPredict !== 1'b1) begin failures++; $display("FAIL cold_hit got=%0b/%0h/%0b exp=1/200/1", IF_Hit, IF_Target, IF_JumpPredict); end
    endtask

    task automatic test_counter();
        logic [3:0] exp_pred = 4'b0001;
        lookup(32'h100);
        ex_set(32'h100, 32'h200, 0, 1, 32'h200);
        checks++; if (Redirect !== 1'b1 || Redirect_PC !== 32'h104) begin failures++; $display("FAIL ctr_redirect got=%0b/%0h exp=1/104", Redirect, Redirect_PC); end
        for (int i = 0; i < 4; i++) begin
            ex_set(32'h100, 32'h200, 0, 1, 32'h200);
            tick();
            checks++; if (IF_Hit !== 1'b1 || IF_JumpPredict !== exp_pred[i] || IF_Target !== 32'h200) begin failures++; $display("FAIL ctr_nt%0d got=%0b/%0b/%0h exp=1/%0b/200", i, IF_Hit, IF_JumpPredict, IF_Target, exp_pred[i]); end
        end
        alloc(32'h100, 32'h240);
        checks++; if (IF_JumpPredict !== 1'b0 || IF_Target !== 32'h240) begin failures++; $display("FAIL ctr_t1 got=%0b/%0h exp=0/240", IF_JumpPredict, IF_Target); end
        alloc(32'h100, 32'h240);
        checks++; if (IF_JumpPredict !== 1'b1) begin failures++; $display("FAIL ctr_t2 got=%0b exp=1", IF_JumpPredict); end
    endtask

    task automatic test_back_to_back();
        lookup(32'hA0);
        ex_set(32'hA0, 32'hC0, 1, 0, 32'h0);
        @(posedge CLK); #1;
        ex_set(32'hA0, 32'hC0, 0, 1, 32'hC0);
        checks++; if (IF_Hit !== 1'b1 || IF_JumpPredict !== 1'b1) begin failures++; $display("FAIL b2b_alloc got=%0b/%0b exp=1/1", IF_Hit, IF_JumpPredict); end
        @(posedge CLK); #1;
        ex_set(32'hA0, 32'hC0, 0, 1, 32'hC0);
        checks++; if (IF_JumpPredict !== 1'b1) begin failures++; $display("FAIL b2b_pre_edge got=%0b exp=1", IF_JumpPredict); end
        tick();
        checks++; if (IF_Hit !== 1'b1 || IF_JumpPredict !== 1'b0) begin failures++; $display("FAIL b2b_final got=%0b/%0b exp=1/0", IF_Hit, IF_JumpPredict); end
    endtask

    task automatic test_redirect();
        ex_set(32'h300, 32'h0, 0, 0, 32'h0);
        checks++; if (Redirect !== 1'b0 || Redirect_PC !== 32'h0) begin failures++; $display("FAIL nt_miss_redirect got=%0b/%0h exp=0/0", Redirect, Redirect_PC); end
        tick();
        lookup(32'h300);
        checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL nt_miss_alloc got=%0b exp=0", IF_Hit); end
        ex_set(32'h310, 32'h600, 1, 1, 32'h500);
        checks++; if (Redirect !== 1'b1 || Redirect_PC !== 32'h600) begin failures++; $display("FAIL wrong_target got=%0b/%0h exp=1/600", Redirect, Redirect_PC); end
        tick();
        lookup(32'h310);
        checks++; if (IF_Hit !== 1'b1 || IF_Target !== 32'h600) begin failures++; $display("FAIL wt_alloc got=%0b/%0h exp=1/600", IF_Hit, IF_Target); end
        ex_set(32'h310, 32'h600, 1, 1, 32'h600);
        checks++; if (Redirect !== 1'b0 || Redirect_PC !== 32'h0) begin failures++; $display("FAIL correct_pred got=%0b/%0h exp=0/0", Redirect, Redirect_PC); end
        ex_set(32'hFFFFFFFC, 32'h0, 0, 1, 32'h0);
        checks++; if (Redirect !== 1'b1 || Redirect_PC !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%0b/%0h exp=1/0", Redirect, Redirect_PC); end
        tick();
    endtask

    task automatic fill8();
        for (int i = 0; i < 8; i++) alloc(32'(i * 4), 32'(32'h1000 + i * 4));
    endtask

    task automatic test_rr_replace();
        Clear = 1;
        tick();
        lookup(32'h100);
        checks++; if (IF_Hit !== 1'b0 || dut.rr_ptr !== 3'd0) begin failures++; $display("FAIL clear got=%0b/%0d exp=0/0", IF_Hit, dut.rr_ptr); end
        fill8();
        lookup(32'h1C);
        checks++; if (IF_Hit !== 1'b1 || IF_Target !== 32'h101C || dut.rr_ptr !== 3'd0) begin failures++; $display("FAIL fill got=%0b/%0h/%0d exp=1/101c/0", IF_Hit, IF_Target, dut.rr_ptr); end
        alloc(32'h40, 32'h2040);
        lookup(32'h00);
        checks++; if (IF_Hit !== 1'b0 || dut.rr_ptr !== 3'd1) begin failures++; $display("FAIL repl0 got=%0b/%0d exp=0/1", IF_Hit, dut.rr_ptr); end
        lookup(32'h40);
        checks++; if (IF_Hit !== 1'b1 || IF_Target !== 32'h2040 || dut.g_entry[0].u_entry.valid !== 1'b1 || dut.target[0] !== 32'h2040) begin failures++; $display("FAIL new40 got=%0b/%0h/%0h exp=1/2040/2040", IF_Hit, IF_Target, dut.target[0]); end
        alloc(32'h44, 32'h2044);
        lookup(32'h04);
        checks++; if (IF_Hit !== 1'b0 || dut.rr_ptr !== 3'd2) begin failures++; $display("FAIL repl1 got=%0b/%0d exp=0/2", IF_Hit, dut.rr_ptr); end
        lookup(32'h08);
        checks++; if (IF_Hit !== 1'b1 || IF_Target !== 32'h1008) begin failures++; $display("FAIL keep08 got=%0b/%0h exp=1/1008", IF_Hit, IF_Target); end
    endtask

    task automatic test_clear_collision();
        ex_set(32'h80, 32'h900, 1, 0, 32'h0);
        Clear = 1; #1;
        checks++; if (Redirect !== 1'b1 || Redirect_PC !== 32'h900) begin failures++; $display("FAIL clr_redirect got=%0b/%0h exp=1/900", Redirect, Redirect_PC); end
        tick();
        lookup(32'h80);
        checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL clr_no_alloc got=%0b exp=0", IF_Hit); end
        lookup(32'h08);
        checks++; if (IF_Hit !== 1'b0 || dut.rr_ptr !== 3'd0) begin failures++; $display("FAIL clr_all got=%0b/%0d exp=0/0", IF_Hit, dut.rr_ptr); end
    endtask

    task automatic test_reset_mid();
        fill8();
        alloc(32'h40, 32'h2040);
        lookup(32'h1C);
        checks++; if (IF_Hit !== 1'b1 || dut.rr_ptr !== 3'd1) begin failures++; $display("FAIL pre_rst got=%0b/%0d exp=1/1", IF_Hit, dut.rr_ptr); end
        ex_set(32'h90, 32'h990, 1, 1, 32'h990);
        #1; RST_N = 0; #1;
        checks++; if (IF_Hit !== 1'b0 || IF_Target !== 32'h0 || dut.rr_ptr !== 3'd0) begin failures++; $display("FAIL mid_rst got=%0b/%0h/%0d exp=0/0/0", IF_Hit, IF_Target, dut.rr_ptr); end
        @(posedge CLK); #1;
        RST_N = 1; EX_Valid = 0;
        lookup(32'h90);
        checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL rst_discard got=%0b exp=0", IF_Hit); end
        alloc(32'h90, 32'h990);
        checks++; if (IF_Hit !== 1'b1 || IF_Target !== 32'h990 || dut.rr_ptr !== 3'd0) begin failures++; $display("FAIL post_rst got=%0b/%0h/%0d exp=1/990/0", IF_Hit, IF_Target, dut.rr_ptr); end
    endtask

    initial begin
        test_reset();
        test_cold_alloc();
        test_counter();
        test_back_to_back();
        test_redirect();
        test_rr_replace();
        test_clear_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
